// File: rtl/latch_bank_write_arbiter.sv
// Two-requester write controller for a DEPTH-word bank of enable-gated latches.
// Each write runs SETUP -> PULSE -> HOLD -> ACK. Define FIXED_PRIORITY_EN for req0-always-wins arbitration.
module latch_bank_write_arbiter #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 6,
  parameter int ADDR_W    = 3,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [WIDTH-1:0]  data0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WIDTH-1:0]  data1,
  output logic              ack0,
  output logic              ack1,
  output logic              err,
  output logic [WIDTH-1:0]  latchData,
  output logic [DEPTH-1:0]  latchEnable,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, ACK} state_e;

  localparam logic [7:0]      SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0]      PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0]      HOLD_LD  = 8'(HOLD_CYC - 1);
  localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W + 1)'(DEPTH);

  state_e              state_q, state_d;
  logic [7:0]          phase_q, phase_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                gnt1_q;
  logic                grant;
  logic                pick1;
  logic                addr_bad;
  logic [DEPTH-1:0]    en_onehot;
  logic                ack0_q, ack1_q, err_q, busy_q;
  logic [WIDTH-1:0]    latch_data_q;
  logic [DEPTH-1:0]    latch_en_q;

  assign grant = (state_q == IDLE) && (req0 || req1);

`ifdef FIXED_PRIORITY_EN
  assign pick1 = req1 && !req0;
`else
  // prio1_q set means requester 1 wins the next tie (requester 0 was granted last).
  logic prio1_q;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      prio1_q <= 1'b0;
    end else if (grant) begin
      prio1_q <= !pick1;
    end
  end

  assign pick1 = req1 && (!req0 || prio1_q);
`endif

  assign addr_bad = ({1'b0, addr_q} >= DEPTH_W);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_en
    localparam logic [ADDR_W:0] IDX = (ADDR_W + 1)'(gi);
    assign en_onehot[gi] = ({1'b0, addr_q} == IDX);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      phase_q <= 8'd0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = SETUP;
          phase_d = SETUP_LD;
        end
      end
      SETUP: begin
        if (phase_q == 8'd0) begin
          state_d = PULSE;
          phase_d = PULSE_LD;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      PULSE: begin
        if (phase_q == 8'd0) begin
          state_d = HOLD;
          phase_d = HOLD_LD;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      HOLD: begin
        if (phase_q == 8'd0) begin
          state_d = ACK;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // latch_data_q doubles as the holding data register: it only changes on the grant edge.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      addr_q       <= '0;
      gnt1_q       <= 1'b0;
      latch_data_q <= '0;
    end else if (grant) begin
      addr_q       <= pick1 ? addr1 : addr0;
      gnt1_q       <= pick1;
      latch_data_q <= pick1 ? data1 : data0;
    end
  end

  // Outputs are registered from the next state so they align with the state they describe.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      latch_en_q <= '0;
    end else begin
      ack0_q     <= (state_d == ACK) && !gnt1_q;
      ack1_q     <= (state_d == ACK) && gnt1_q;
      err_q      <= (state_d == ACK) && addr_bad;
      busy_q     <= (state_d != IDLE);
      latch_en_q <= (state_d == PULSE) ? en_onehot : '0;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign latchData   = latch_data_q;
  assign latchEnable = latch_en_q;

endmodule

// File: tb/tb_latch_bank_write_arbiter.sv
// Self-checking bench for latch_bank_write_arbiter: scoreboard of expected grants plus timing checks,
// with a second instance covering a non-default SETUP/PULSE/HOLD setting.
module tb_latch_bank_write_arbiter;

  logic       clock = 1'b0;
  logic       resetN;
  logic       req0, req1;
  logic [2:0] addr0, addr1;
  logic [7:0] data0, data1;
  logic       ack0, ack1, err, busy;
  logic [7:0] latchData;
  logic [5:0] latchEnable;

  logic       sw_req0, sw_req1;
  logic [2:0] sw_addr0, sw_addr1;
  logic [7:0] sw_data0, sw_data1;
  logic       sw_ack0, sw_ack1, sw_err, sw_busy;
  logic [7:0] sw_latchData;
  logic [5:0] sw_latchEnable;

  always #5 clock = ~clock;

  latch_bank_write_arbiter #(.WIDTH(8), .DEPTH(6), .ADDR_W(3),
                             .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) dut (
    .clock(clock), .resetN(resetN),
    .req0(req0), .addr0(addr0), .data0(data0),
    .req1(req1), .addr1(addr1), .data1(data1),
    .ack0(ack0), .ack1(ack1), .err(err),
    .latchData(latchData), .latchEnable(latchEnable), .busy(busy)
  );

  latch_bank_write_arbiter #(.WIDTH(8), .DEPTH(6), .ADDR_W(3),
                             .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) u_sweep (
    .clock(clock), .resetN(resetN),
    .req0(sw_req0), .addr0(sw_addr0), .data0(sw_data0),
    .req1(sw_req1), .addr1(sw_addr1), .data1(sw_data1),
    .ack0(sw_ack0), .ack1(sw_ack1), .err(sw_err),
    .latchData(sw_latchData), .latchEnable(sw_latchEnable), .busy(sw_busy)
  );

  typedef struct {
    int         who;
    logic [2:0] addr;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  logic m_prio1 = 1'b0;

  int         o_en_first, o_en_len, o_ack_k;
  logic [5:0] o_en_val;
  logic       o_a0, o_a1, o_err, o_stable;
  logic [7:0] o_data;

  // Reference arbitration: predicts the winner from the requests currently driven.
  task automatic push_expected(input logic r0, input logic r1);
    exp_t e;
    int   w;
`ifdef FIXED_PRIORITY_EN
    w = r0 ? 0 : 1;
`else
    w = (r0 && !(r1 && m_prio1)) ? 0 : 1;
`endif
    m_prio1 = (w == 0);
    e.who  = w;
    e.addr = (w == 1) ? addr1 : addr0;
    e.data = (w == 1) ? data1 : data0;
    e.err  = (e.addr >= 3'd6);
    sb.push_back(e);
  endtask

  // Records one write on the main instance; sample 0 is the negedge right after the grant edge.
  task automatic observe(input logic drop0, input logic drop1);
    o_en_first = -1; o_en_len = 0; o_en_val = '0; o_ack_k = -1;
    o_a0 = 1'b0; o_a1 = 1'b0; o_err = 1'b0; o_stable = 1'b1; o_data = '0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (k == 0) o_data = latchData;
      else if (latchData !== o_data) o_stable = 1'b0;
      if (latchEnable !== 6'b0) begin
        if (o_en_first < 0) o_en_first = k;
        o_en_len++;
        o_en_val = o_en_val | latchEnable;
      end
      if (ack0 || ack1) begin
        o_ack_k = k; o_a0 = ack0; o_a1 = ack1; o_err = err;
        if (ack0 && drop0) req0 = 1'b0;
        if (ack1 && drop1) req1 = 1'b0;
        break;
      end
    end
  endtask

  function automatic int acked_who();
    if (o_a0 && !o_a1) return 0;
    if (o_a1 && !o_a0) return 1;
    return -1;
  endfunction

  task automatic test_reset();
    resetN = 1'b0;
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; data0 = 0; data1 = 0;
    sw_req0 = 0; sw_req1 = 0; sw_addr0 = 0; sw_addr1 = 0; sw_data0 = 0; sw_data1 = 0;
    repeat (2) @(negedge clock);
    checks++; if (ack0 !== 1'b0) $display("FAIL reset_ack0 got %b exp 0", ack0); else passed++;
    checks++; if (ack1 !== 1'b0) $display("FAIL reset_ack1 got %b exp 0", ack1); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    checks++; if (latchData !== 8'h00) $display("FAIL reset_data got %h exp 00", latchData); else passed++;
    checks++; if (latchEnable !== 6'b0) $display("FAIL reset_en got %b exp 000000", latchEnable); else passed++;
    resetN = 1'b1;
    @(negedge clock);
    checks++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b exp 0", busy); else passed++;
  endtask

  task automatic test_single_write();
    exp_t e;
    req0 = 1; addr0 = 3'd2; data0 = 8'hA5;
    push_expected(req0, req1);
    observe(1'b1, 1'b0);
    checks++;
    if (sb.size() == 0) $display("FAIL single_sb got 0 entries exp 1");
    else begin
      passed++;
      e = sb.pop_front();
      checks++; if (acked_who() != e.who) $display("FAIL single_who got %0d exp %0d", acked_who(), e.who); else passed++;
      checks++; if (o_data !== e.data) $display("FAIL single_data got %h exp %h", o_data, e.data); else passed++;
      checks++; if (o_err !== e.err) $display("FAIL single_err got %b exp %b", o_err, e.err); else passed++;
    end
    checks++; if (o_stable !== 1'b1) $display("FAIL single_data_stable got %b exp 1", o_stable); else passed++;
    checks++; if (o_en_val !== 6'b000100) $display("FAIL single_en got %b exp 000100", o_en_val); else passed++;
    checks++; if (o_en_first != 1) $display("FAIL single_en_start got %0d exp 1", o_en_first); else passed++;
    checks++; if (o_en_len != 2) $display("FAIL single_en_len got %0d exp 2", o_en_len); else passed++;
    checks++; if (o_ack_k != 4) $display("FAIL single_ack_lat got %0d exp 4", o_ack_k); else passed++;
    @(negedge clock);
    checks++; if (ack0 !== 1'b0) $display("FAIL single_ack_width got %b exp 0", ack0); else passed++;
  endtask

  task automatic test_out_of_range();
    exp_t e;
    req1 = 1; addr1 = 3'd7; data1 = 8'h3C;
    push_expected(req0, req1);
    observe(1'b0, 1'b1);
    checks++;
    if (sb.size() == 0) $display("FAIL oor_sb got 0 entries exp 1");
    else begin
      passed++;
      e = sb.pop_front();
      checks++; if (acked_who() != e.who) $display("FAIL oor_who got %0d exp %0d", acked_who(), e.who); else passed++;
      checks++; if (o_err !== e.err) $display("FAIL oor_err got %b exp %b", o_err, e.err); else passed++;
      checks++; if (o_data !== e.data) $display("FAIL oor_data got %h exp %h", o_data, e.data); else passed++;
    end
    checks++; if (o_en_val !== 6'b0) $display("FAIL oor_en got %b exp 000000", o_en_val); else passed++;
    checks++; if (o_ack_k != 4) $display("FAIL oor_ack_lat got %0d exp 4", o_ack_k); else passed++;
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [5:0] exp_en;
    req0 = 1; addr0 = 3'd0; data0 = 8'h0F;
    for (int t = 0; t < 2; t++) begin
      push_expected(req0, req1);
      observe(t == 1, 1'b0);
      checks++;
      if (sb.size() == 0) $display("FAIL b2b_sb got 0 entries exp 1");
      else begin
        passed++;
        e = sb.pop_front();
        exp_en = (e.addr < 3'd6) ? (6'b000001 << e.addr) : 6'b0;
        checks++; if (acked_who() != e.who) $display("FAIL b2b_who[%0d] got %0d exp %0d", t, acked_who(), e.who); else passed++;
        checks++; if (o_en_val !== exp_en) $display("FAIL b2b_en[%0d] got %b exp %b", t, o_en_val, exp_en); else passed++;
        checks++; if (o_data !== e.data) $display("FAIL b2b_data[%0d] got %h exp %h", t, o_data, e.data); else passed++;
      end
      checks++; if (o_en_len != 2) $display("FAIL b2b_en_len[%0d] got %0d exp 2", t, o_en_len); else passed++;
      if (t == 0) begin addr0 = 3'd5; data0 = 8'hF0; end
      @(negedge clock);
      checks++; if (busy !== 1'b0) $display("FAIL b2b_idle_gap[%0d] got busy %b exp 0", t, busy); else passed++;
    end
  endtask

  task automatic test_contention();
    exp_t e;
    @(negedge clock);
    resetN = 1'b0; m_prio1 = 1'b0;
    req0 = 1; addr0 = 3'd1; data0 = 8'h11;
    req1 = 1; addr1 = 3'd3; data1 = 8'h22;
    @(negedge clock);
    resetN = 1'b1;
    // Two rounds from reset, then a lone req0 followed by a tie to exercise the pointer.
    for (int round = 0; round < 3; round++) begin
      if (round == 2) begin
        req0 = 1; req1 = 0;
        push_expected(req0, req1);
        observe(1'b1, 1'b1);
        if (sb.size() != 0) e = sb.pop_front();
        checks++; if (acked_who() != 0) $display("FAIL cont_lone_who got %0d exp 0", acked_who()); else passed++;
        @(negedge clock);
      end
      req0 = 1; req1 = 1;
      for (int t = 0; t < 2; t++) begin
        push_expected(req0, req1);
        observe(1'b1, 1'b1);
        checks++;
        if (sb.size() == 0) $display("FAIL cont_sb got 0 entries exp 1");
        else begin
          passed++;
          e = sb.pop_front();
          checks++; if (acked_who() != e.who) $display("FAIL cont_who[%0d.%0d] got %0d exp %0d", round, t, acked_who(), e.who); else passed++;
          checks++; if (o_data !== e.data) $display("FAIL cont_data[%0d.%0d] got %h exp %h", round, t, o_data, e.data); else passed++;
        end
        @(negedge clock);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    exp_t e;
    logic hit;
    logic saw_ack;
    req0 = 1; addr0 = 3'd1; data0 = 8'h77; req1 = 0;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clock);
      if (latchEnable === 6'b000010) hit = 1'b1;
    end
    checks++; if (!hit) $display("FAIL rst_mid_reach got %b exp 1", hit); else passed++;
    #1 resetN = 1'b0;
    #1;
    checks++; if (latchEnable !== 6'b0) $display("FAIL rst_mid_en got %b exp 000000", latchEnable); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b exp 0", busy); else passed++;
    checks++; if (latchData !== 8'h00) $display("FAIL rst_mid_data got %h exp 00", latchData); else passed++;
    m_prio1 = 1'b0;
    saw_ack = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (ack0 || ack1) saw_ack = 1'b1;
    end
    checks++; if (saw_ack !== 1'b0) $display("FAIL rst_mid_noack got %b exp 0", saw_ack); else passed++;
    req0 = 1; addr0 = 3'd4; data0 = 8'h44;
    req1 = 1; addr1 = 3'd2; data1 = 8'h12;
    resetN = 1'b1;
    for (int t = 0; t < 2; t++) begin
      push_expected(req0, req1);
      observe(1'b1, 1'b1);
      checks++;
      if (sb.size() == 0) $display("FAIL rst_mid_sb got 0 entries exp 1");
      else begin
        passed++;
        e = sb.pop_front();
        checks++; if (acked_who() != e.who) $display("FAIL rst_mid_who[%0d] got %0d exp %0d", t, acked_who(), e.who); else passed++;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_sweep();
    int         en_first, en_len, ack_k;
    logic [5:0] en_val;
    en_first = -1; en_len = 0; ack_k = -1; en_val = '0;
    sw_req0 = 1; sw_addr0 = 3'd4; sw_data0 = 8'h5A;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (sw_latchEnable !== 6'b0) begin
        if (en_first < 0) en_first = k;
        en_len++;
        en_val = en_val | sw_latchEnable;
      end
      if (sw_ack0 || sw_ack1) begin
        ack_k = k;
        sw_req0 = 0;
        break;
      end
    end
    checks++; if (en_first != 3) $display("FAIL sweep_en_start got %0d exp 3", en_first); else passed++;
    checks++; if (en_len != 1) $display("FAIL sweep_en_len got %0d exp 1", en_len); else passed++;
    checks++; if (en_val !== 6'b010000) $display("FAIL sweep_en got %b exp 010000", en_val); else passed++;
    checks++; if (ack_k != 6) $display("FAIL sweep_ack_lat got %0d exp 6", ack_k); else passed++;
    checks++; if (sw_latchData !== 8'h5A) $display("FAIL sweep_data got %h exp 5a", sw_latchData); else passed++;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_out_of_range();
    test_back_to_back();
    test_contention();
    test_reset_mid_pulse();
    test_sweep();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/latch_bank_write_arbiter.md
Name: latch_bank_write_arbiter

Overview:
- Controller that shares one bank of enable-gated D latches between two requesters.
- Arbitrates write requests and sequences each write as data setup, enable pulse, then data hold.
- Returns a one-cycle acknowledge to the winning requester.
- Sits between the lab's requester logic (switch or FSM drivers) and a DEPTH-word latch bank; it owns every latch-enable line in that bank.

Parameters:
- WIDTH, 8: data width of each latch word.
- DEPTH, 6: number of latch words (one enable line per word).
- ADDR_W, 3: address width; must satisfy 2^ADDR_W >= DEPTH.
- SETUP_CYC, 1: cycles latchData is stable before enable rises (>=1).
- PULSE_CYC, 2: cycles the enable is high (>=1).
- HOLD_CYC, 1: cycles latchData is held after enable falls (>=1).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- resetN  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 write request; held high until ack0.
- addr0  in  ADDR_W  requester 0 target word.
- data0  in  WIDTH  requester 0 write data.
- req1  in  1  requester 1 write request.
- addr1  in  ADDR_W  requester 1 target word.
- data1  in  WIDTH  requester 1 write data.
- ack0  out  1  one-cycle write-complete pulse to requester 0.
- ack1  out  1  one-cycle write-complete pulse to requester 1.
- err  out  1  pulses with the ack when the address is >= DEPTH.
- latchData  out  WIDTH  data bus driven to all latch D inputs.
- latchEnable  out  DEPTH  one-hot latch enables; all zero outside PULSE.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-low): on resetN low, immediately and independently of clock:
  - all outputs go to 0;
  - state goes to IDLE;
  - round-robin pointer favours req0.
  - Reset mid-write aborts the write: enable drops at once and no ack is issued.
- States: IDLE -> SETUP -> PULSE -> HOLD -> ACK -> IDLE. An 8-bit phase counter times SETUP, PULSE and HOLD.
- IDLE:
  - At an edge with req0 or req1 high, grant one requester.
  - Capture its addr and data into holding registers, record the grantee, and go to SETUP.
  - Inputs are ignored after capture.
- Arbitration:
  - Only one request pending: it wins.
  - Both pending: the requester not granted most recently wins (round robin).
  - The pointer updates at grant.
- latchData:
  - equals the holding data in SETUP, PULSE and HOLD;
  - keeps its last value in IDLE and ACK;
  - is 0 only after reset.
- SETUP: lasts SETUP_CYC cycles, with all latch enables low.
- PULSE:
  - lasts PULSE_CYC cycles;
  - latchEnable[addr] is high, all other bits low;
  - if addr >= DEPTH, all enables stay low.
- HOLD: lasts HOLD_CYC cycles, with enables low and data held.
- ACK:
  - lasts one cycle;
  - the grantee's ack is high;
  - err is high in the same cycle if addr >= DEPTH;
  - the next state is IDLE.
- Latency:
  - Enable rises SETUP_CYC edges after the grant edge.
  - Ack rises SETUP_CYC+PULSE_CYC+HOLD_CYC edges after the grant edge (4 with defaults).
  - Minimum request-to-request spacing is that latency plus 2 cycles (ACK, IDLE).
- Requesters drop req on the edge ending their ack cycle. IDLE re-samples on the next edge, so a still-high req is treated as a new request.
- A request arriving during busy waits; it is never lost while held.
- Outputs ack0, ack1, err, latchEnable and busy are registered and glitch-free; enable is never high in the same cycle that latchData changes.

Optional Feature:
- Macro FIXED_PRIORITY_EN.
- Defined: req0 always wins when both are pending; the round-robin pointer is removed.
- Undefined: round-robin arbitration as above.
- All other timing is identical in both builds.

Test Plan:
- Single write: req0=1, addr0=2, data0=0xA5 -> latchData=0xA5 for 4 cycles; latchEnable=6'b000100 for exactly 2 cycles, starting 1 edge after grant; ack0 pulses 1 cycle, 4 edges after grant; err=0.
- Contention: req0 and req1 both high from reset, held until acked -> grants go req0, then req1. Rerequesting both gives req0, then req1 again; with FIXED_PRIORITY_EN, req0 wins every contention.
- Out of range: req1=1, addr1=7, data1=0x3C -> latchEnable stays 0 throughout; ack1 and err both pulse in the same cycle.
- Back-to-back: req0 held high through two writes (addr 0 then 5) -> two separate enable pulses, with IDLE between ACK and the second SETUP.
- Reset mid-PULSE: assert resetN=0 while latchEnable=6'b000010 -> enables, ack, busy and latchData go to 0 immediately, with no ack. After release, IDLE is reached and req0 wins the first contention.
- Parameter sweep: SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=2 -> enable high 1 cycle, 3 edges after grant; ack 6 edges after grant.
